// File: rtl/rgb_pixel_serializer.sv
// Buffers 24-bit RGB pixels in a small FIFO and serializes them as R, G, B bytes
// to a UART transmitter, one send strobe every BYTE_GAP cycles.
module rgb_pixel_serializer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BYTE_GAP   = 16'd52080
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       data_in_valid,
  input  logic [7:0] r_data_in,
  input  logic [7:0] g_data_in,
  input  logic [7:0] b_data_in,
  output logic [7:0] data_out,
  output logic       data_out_ready,
  output logic       fifo_full,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [23:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty;
  logic        push, pop;

  logic [23:0] hold;
  logic [1:0]  byte_idx;
  logic        byte_inc;
  logic [15:0] gap_cnt;
  logic        gap_end;
  logic [7:0]  hold_byte;

  // Extra pointer bit tells a full FIFO from an empty one when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = data_in_valid && (!fifo_full || pop);
  assign gap_end    = (gap_cnt == BYTE_GAP - 16'd2);
  assign busy       = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    case (byte_idx)
      2'd0:    hold_byte = hold[23:16];
      2'd1:    hold_byte = hold[15:8];
      default: hold_byte = hold[7:0];
    endcase
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    byte_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: state_d = GAP;
      GAP: begin
        if (gap_end) begin
          if (byte_idx != 2'd2) begin
            byte_inc = 1'b1;
            state_d  = SEND;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: pixel storage carries no reset; emptiness is defined by the pointers,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {r_data_in, g_data_in, b_data_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, e.g. a same-cycle write and pop on a full FIFO.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      hold           <= '0;
      byte_idx       <= '0;
      gap_cnt        <= '0;
      data_out       <= '0;
      data_out_ready <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_out_ready <= (state_q == SEND);

      if (state_q == SEND) begin
        data_out <= hold_byte;
        gap_cnt  <= '0;
      end else if (state_q == GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end

      if (pop) begin
        hold     <= mem[rd_ptr[AW-1:0]];
        byte_idx <= '0;
        rd_ptr   <= rd_ptr + 1'b1;
      end else if (byte_inc) begin
        byte_idx <= byte_idx + 2'd1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (data_in_valid && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_pixel_serializer.sv
// Self-checking bench: a transmit-schedule model predicts every output each cycle,
// and directed scenarios pin absolute strobe times and bytes.
module tb_rgb_pixel_serializer;

  localparam int G = 8;
  localparam int D = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       data_in_valid = 1'b0;
  logic [7:0] r_data_in = '0, g_data_in = '0, b_data_in = '0;
  logic [7:0] data_out;
  logic       data_out_ready, fifo_full, overflow, busy;

  rgb_pixel_serializer #(.FIFO_DEPTH(D), .BYTE_GAP(16'd8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in_valid(data_in_valid),
    .r_data_in(r_data_in), .g_data_in(g_data_in), .b_data_in(b_data_in),
    .data_out(data_out), .data_out_ready(data_out_ready),
    .fifo_full(fifo_full), .overflow(overflow), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- reference model: pixel queue + byte schedule ----------------
  typedef struct { int wr; logic [23:0] px; } ent_t;
  typedef struct { int t;  logic [7:0] b;   } stb_t;
  ent_t mq[$];
  stb_t eq[$];
  int         last_pop = -1000;
  logic [7:0] exp_dout = '0;
  logic       exp_rdy = 1'b0, exp_full = 1'b0, exp_ovf = 1'b0, exp_busy = 1'b0;

  // A pixel leaves the queue one cycle after it arrived, but never before the
  // previous pixel's three byte slots (3*G cycles from its pop) have elapsed.
  always @(posedge sys_clk) begin
    ent_t e;
    logic pop_now, acc;
    cyc = cyc + 1;
    if (sys_rst) begin
      mq.delete();
      eq.delete();
      last_pop = -1000;
      exp_ovf  = 1'b0;
      exp_dout = '0;
      exp_rdy  = 1'b0;
    end else begin
      pop_now = 1'b0;
      if (mq.size() > 0 && imax(last_pop + 3 * G, mq[0].wr + 1) == cyc) pop_now = 1'b1;
      acc = data_in_valid && (mq.size() < D || pop_now);
      if (pop_now) begin
        e = mq.pop_front();
        last_pop = cyc;
        eq.push_back('{cyc + 1,         e.px[23:16]});
        eq.push_back('{cyc + 1 + G,     e.px[15:8]});
        eq.push_back('{cyc + 1 + 2 * G, e.px[7:0]});
      end
      if (acc) mq.push_back('{cyc, {r_data_in, g_data_in, b_data_in}});
      else if (data_in_valid) exp_ovf = 1'b1;
      exp_rdy = (eq.size() > 0 && eq[0].t == cyc);
      if (exp_rdy) begin
        exp_dout = eq[0].b;
        void'(eq.pop_front());
      end
    end
    exp_full = (mq.size() == D);
    exp_busy = (mq.size() > 0) || (cyc < last_pop + 3 * G);
  end

  // ---------------- compare process + logging ----------------
  int         stb_cyc[$];
  logic [7:0] stb_byte[$];
  int         busy_fall = -1;
  logic       prev_busy = 1'b0;
  logic       full_seen = 1'b0;
  int         probe_cyc = -1;
  logic [7:0] pr_dout;
  logic       pr_rdy, pr_full, pr_ovf, pr_busy;

  always @(negedge sys_clk) begin
    if (cyc > 0) begin
      check("data_out_ready", data_out_ready, exp_rdy);
      check("data_out", data_out, exp_dout);
      check("fifo_full", fifo_full, exp_full);
      check("overflow", overflow, exp_ovf);
      check("busy", busy, exp_busy);
      if (data_out_ready) begin
        stb_cyc.push_back(cyc);
        stb_byte.push_back(data_out);
      end
      if (fifo_full) full_seen = 1'b1;
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy;
      if (cyc == probe_cyc) begin
        pr_dout = data_out; pr_rdy = data_out_ready; pr_full = fifo_full;
        pr_ovf = overflow; pr_busy = busy;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [23:0] px);
    @(posedge sys_clk);
    #1;
    data_in_valid = v;
    {r_data_in, g_data_in, b_data_in} = px;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    drive(1'b0, 24'h0);
    while ((busy || data_in_valid) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (2) @(negedge sys_clk);
    check("drain_within_budget", (n < budget), 1'b1);
  endtask

  task automatic clear_logs();
    stb_cyc.delete();
    stb_byte.delete();
    full_seen = 1'b0;
    busy_fall = -1;
  endtask

  task automatic check_bytes(input string name, input logic [23:0] px[$]);
    for (int i = 0; i < px.size(); i++) begin
      check(name, stb_byte[3 * i],     px[i][23:16]);
      check(name, stb_byte[3 * i + 1], px[i][15:8]);
      check(name, stb_byte[3 * i + 2], px[i][7:0]);
    end
  endtask

  initial begin
    int t, t2;
    logic [23:0] pl[$];

    repeat (3) drive(1'b0, 24'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("reset_data_out", data_out, 8'h00);
    check("reset_ready", data_out_ready, 1'b0);
    check("reset_busy", busy, 1'b0);

    // 1: one pixel, absolute timing
    clear_logs();
    drive(1'b1, 24'h123456); t = cyc + 1;
    wait_idle(200);
    check("t1_count", stb_cyc.size(), 3);
    check("t1_r_time", stb_cyc[0], t + 2);
    check("t1_g_time", stb_cyc[1], t + 10);
    check("t1_b_time", stb_cyc[2], t + 18);
    pl = '{24'h123456};
    check_bytes("t1_bytes", pl);
    check("t1_busy_fall", busy_fall, t + 25);
    check("t1_overflow", overflow, 1'b0);

    // 2: four back-to-back pixels fit without filling the FIFO
    clear_logs();
    pl = '{24'h010203, 24'h111213, 24'h212223, 24'h313233};
    foreach (pl[i]) drive(1'b1, pl[i]);
    wait_idle(400);
    check("t2_count", stb_cyc.size(), 12);
    for (int i = 1; i < 12; i++) check("t2_spacing", stb_cyc[i] - stb_cyc[i - 1], G);
    check_bytes("t2_bytes", pl);
    check("t2_full_seen", full_seen, 1'b0);
    check("t2_overflow", overflow, 1'b0);

    // 5: full FIFO plus write in the cycle the last gap ends -> accepted
    clear_logs();
    pl = '{24'h405060, 24'h415161, 24'h425262, 24'h435363, 24'h445464};
    drive(1'b1, pl[0]); t = cyc + 1;
    for (int i = 1; i < 5; i++) drive(1'b1, pl[i]);
    probe_cyc = t + 24;
    while (cyc < t + 23) drive(1'b0, 24'h0);
    drive(1'b1, 24'hC0FFEE);
    pl.push_back(24'hC0FFEE);
    wait_idle(800);
    check("t5_full_before", pr_full, 1'b1);
    check("t5_overflow", overflow, 1'b0);
    check("t5_count", stb_cyc.size(), 18);
    check_bytes("t5_bytes", pl);

    // 3: six back-to-back pixels, the sixth is dropped
    clear_logs();
    pl = '{24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 24'hD1D2D3, 24'hE1E2E3};
    drive(1'b1, pl[0]); t = cyc + 1;
    for (int i = 1; i < 5; i++) drive(1'b1, pl[i]);
    probe_cyc = t + 5;
    drive(1'b1, 24'hDEAD00);
    wait_idle(800);
    check("t3_full_at_t5", pr_full, 1'b1);
    check("t3_count", stb_cyc.size(), 15);
    check_bytes("t3_bytes", pl);
    check("t3_overflow_sticky", overflow, 1'b1);

    // 4: reset during the gap after G abandons B
    clear_logs();
    drive(1'b1, 24'h778899); t = cyc + 1;
    probe_cyc = t + 12;
    while (cyc < t + 11) drive(1'b0, 24'h0);
    sys_rst = 1'b1;
    drive(1'b0, 24'h0);
    sys_rst = 1'b0;
    {pr_dout, pr_rdy, pr_full, pr_ovf, pr_busy} = '1;
    repeat (3) drive(1'b0, 24'h0);
    check("t4_rst_dout", pr_dout, 8'h00);
    check("t4_rst_ready", pr_rdy, 1'b0);
    check("t4_rst_full", pr_full, 1'b0);
    check("t4_rst_ovf", pr_ovf, 1'b0);
    check("t4_rst_busy", pr_busy, 1'b0);
    drive(1'b1, 24'hAABBCC); t2 = cyc + 1;
    wait_idle(200);
    check("t4_count", stb_cyc.size(), 5);
    check("t4_g_before_rst", stb_byte[1], 8'h88);
    check("t4_new_time", stb_cyc[2], t2 + 2);
    check("t4_new_byte", stb_byte[2], 8'hAA);

    // random traffic at three densities, checked every cycle by the model
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 600; c++)
        drive(($urandom_range(0, (ph == 0) ? 1 : (ph == 1) ? 9 : 29) == 0), 24'($urandom));
      wait_idle(1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
